// File: rtl/mac_accumulator.sv
// Accumulates a stream of 32-bit unsigned products into an ACC_W-bit sum.
// Raises a sticky overflow flag on wrap and holds the result until downstream takes it.
module mac_accumulator #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             prod_valid,
  input  logic [31:0]      prod,
  output logic             prod_ready,
  output logic             sum_valid,
  output logic [ACC_W-1:0] sum,
  input  logic             sum_ready,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic             prod_ready_q, prod_ready_d;
  logic             sum_valid_q, sum_valid_d;
  logic             busy_q, busy_d;

  logic             beat;
  logic [ACC_W:0]   acc_sum;

  // prod_ready_q is high exactly while in ACC, so it doubles as the state qualifier
  assign beat    = prod_valid && prod_ready_q;
  assign acc_sum = {1'b0, acc_q} + {{(ACC_W + 1 - 32){1'b0}}, prod};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          rem_d   = len;
          state_d = (len == '0) ? HOLD : ACC;
        end
      end
      ACC: begin
        if (beat) begin
          acc_d = acc_sum[ACC_W-1:0];
          if (acc_sum[ACC_W]) ovf_d = 1'b1;
          if (rem_q != '0) rem_d = rem_q - CNT_ONE;
          if (rem_q <= CNT_ONE) state_d = HOLD;
        end
      end
      HOLD: begin
        if (sum_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    prod_ready_d = (state_d == ACC);
    sum_valid_d  = (state_d == HOLD);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      rem_q        <= '0;
      ovf_q        <= 1'b0;
      prod_ready_q <= 1'b0;
      sum_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      rem_q        <= rem_d;
      ovf_q        <= ovf_d;
      prod_ready_q <= prod_ready_d;
      sum_valid_q  <= sum_valid_d;
      busy_q       <= busy_d;
    end
  end

  // acc is only cleared by start or reset, so in IDLE it still shows the last result
  assign sum        = acc_q;
  assign overflow   = ovf_q;
  assign prod_ready = prod_ready_q;
  assign sum_valid  = sum_valid_q;
  assign busy       = busy_q;

endmodule
